// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one cache request at a time onto the single RAM port.
// Cores are scanned round-robin from rr. Within a core, the data request
// wins over the instruction fetch. The wait bits are the caches'
// completion handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transfer; choose the next requester and latch it
// GRANT | RAM port driven from the latched requester until ACCESS or abort
module mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] iload,
  output logic [CPUS*WORD_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [CW-1:0] gntCpu;
  logic          gntD;
  logic [CW-1:0] rr;

  logic [CW-1:0] selCpu;
  logic [CW-1:0] scanSel;
  logic          selD;
  logic          anyReq;
  logic          reqLive;
  logic          done;
  logic [CW-1:0] rrNext;
  int            scanIdx;

  logic [WORD_W-1:0] iaddrA  [CPUS];
  logic [WORD_W-1:0] daddrA  [CPUS];
  logic [WORD_W-1:0] dstoreA [CPUS];

  // Unpack the flat per-core buses so the granted core can be indexed directly.
  for (genvar c = 0; c < CPUS; c++) begin : gUnpack
    assign iaddrA[c]  = iaddr[c*WORD_W +: WORD_W];
    assign daddrA[c]  = daddr[c*WORD_W +: WORD_W];
    assign dstoreA[c] = dstore[c*WORD_W +: WORD_W];
  end

  // Read data is broadcast; each cache samples it only when its wait bit is low.
  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  // Round-robin scan from rr: the first core with any request wins, data before instruction.
  always_comb begin
    anyReq  = 1'b0;
    selCpu  = '0;
    selD    = 1'b0;
    scanIdx = 0;
    scanSel = '0;
    for (int k = 0; k < CPUS; k++) begin
      scanIdx = int'(rr) + k;
      if (scanIdx >= CPUS) scanIdx = scanIdx - CPUS;
      scanSel = CW'(scanIdx);
      if (!anyReq && (dREN[scanSel] || dWEN[scanSel] || iREN[scanSel])) begin
        anyReq = 1'b1;
        selCpu = scanSel;
        selD   = dREN[scanSel] | dWEN[scanSel];
      end
    end
  end

  // RAM port and wait bits follow the granted requester's live inputs so an abort or reset drops them at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    reqLive  = 1'b0;
    done     = 1'b0;
    if (state == GRANT) begin
      reqLive = gntD ? (dREN[gntCpu] | dWEN[gntCpu]) : iREN[gntCpu];
      if (reqLive) begin
        done = (ramstate == RAM_ACCESS);
        if (gntD) begin
          ramaddr = daddrA[gntCpu];
          if (dWEN[gntCpu]) begin
            ramWEN   = 1'b1;
            ramstore = dstoreA[gntCpu];
          end else begin
            ramREN = 1'b1;
          end
          dwait[gntCpu] = ~done;
        end else begin
          ramaddr       = iaddrA[gntCpu];
          ramREN        = 1'b1;
          iwait[gntCpu] = ~done;
        end
      end
    end
  end

  // Pointer moves to the core after the one just served, wrapping at CPUS.
  always_comb begin
    rrNext = gntCpu + 1'b1;
    if (int'(gntCpu) == CPUS - 1) rrNext = '0;
  end

  // Grant FSM: latch the selection in IDLE, leave GRANT on completion (advance rr) or abort (keep rr).
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      gntCpu <= '0;
      gntD   <= 1'b0;
      rr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            state  <= GRANT;
            gntCpu <= selCpu;
            gntD   <= selD;
          end
        end
        GRANT: begin
          if (!reqLive) begin
            state <= IDLE;
          end else if (done) begin
            state <= IDLE;
            rr    <= rrNext;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 ns after the rising edge;
// outputs are sampled on the falling edge.
module tb_mem_arbiter;

  localparam int CPUS = 2;
  localparam int W    = 32;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  // Priority sequence, cycles 0..8: idle, c0-data, idle, c1-data, idle, c0-instr, idle, c1-instr, idle
  localparam logic [31:0] EXP_ADDR [9] = '{32'h0, 32'h2000, 32'h0, 32'h2100, 32'h0,
                                          32'h1000, 32'h0, 32'h1100, 32'h0};
  localparam logic [31:0] EXP_REN  [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  // {dwait, iwait}
  localparam logic [31:0] EXP_WAIT [9] = '{32'hF, 32'hB, 32'hF, 32'h7, 32'hF,
                                          32'hE, 32'hF, 32'hD, 32'hF};

  logic              CLK = 1'b0;
  logic              nRST;
  logic [CPUS-1:0]   iREN, dREN, dWEN;
  logic [CPUS*W-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]   iwait, dwait;
  logic [CPUS*W-1:0] iload, dload;
  logic              ramREN, ramWEN;
  logic [W-1:0]      ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;

  int nChecks = 0;
  int nErrors = 0;
  logic [CPUS-1:0] prevIwait, prevDwait;

  mem_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic startCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  initial begin
    nRST     = 1'b0;
    iREN     = '1;
    dREN     = '1;
    dWEN     = '1;
    iaddr    = {32'h1100, 32'h1000};
    daddr    = {32'h2100, 32'h2000};
    dstore   = {32'hAAAA5555, 32'h5555AAAA};
    ramload  = 32'hDEADBEEF;
    ramstate = ACCESS;

    // reset with every request high
    #3;
    checkVal("rst_iwait", 32'(iwait), 32'h3);
    checkVal("rst_dwait", 32'(dwait), 32'h3);
    checkVal("rst_ren", 32'(ramREN), 32'h0);
    checkVal("rst_wen", 32'(ramWEN), 32'h0);
    checkVal("rst_addr", ramaddr, 32'h0);
    checkVal("rst_store", ramstore, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    checkVal("rst_clk_ren", 32'(ramREN), 32'h0);
    checkVal("rst_clk_wait", {28'h0, dwait, iwait}, 32'hF);
    iREN = '0;
    dREN = '0;
    dWEN = '0;
    nRST = 1'b1;

    // single instruction read, ACCESS immediately
    startCycle();
    iREN         = 2'b01;
    iaddr[31:0]  = 32'h100;
    sample();
    checkVal("rd_idle_ren", 32'(ramREN), 32'h0);
    checkVal("rd_idle_iwait", 32'(iwait), 32'h3);
    startCycle();
    sample();
    checkVal("rd_ren", 32'(ramREN), 32'h1);
    checkVal("rd_addr", ramaddr, 32'h100);
    checkVal("rd_iwait", 32'(iwait), 32'h2);
    checkVal("rd_iload0", iload[31:0], 32'hDEADBEEF);
    checkVal("rd_dload1", dload[63:32], 32'hDEADBEEF);
    startCycle();
    iREN = '0;
    sample();
    checkVal("rd_after_ren", 32'(ramREN), 32'h0);
    checkVal("rd_after_iwait", 32'(iwait), 32'h3);

    // core 1 write, 3 BUSY cycles then ACCESS (rr is now 1)
    startCycle();
    dWEN          = 2'b10;
    daddr[63:32]  = 32'h40;
    dstore[63:32] = 32'h12345678;
    ramstate      = BUSY;
    sample();
    checkVal("wr_idle_wen", 32'(ramWEN), 32'h0);
    for (int i = 0; i < 4; i++) begin
      startCycle();
      if (i == 3) ramstate = ACCESS;
      sample();
      checkVal($sformatf("wr_wen_%0d", i), 32'(ramWEN), 32'h1);
      checkVal($sformatf("wr_ren_%0d", i), 32'(ramREN), 32'h0);
      checkVal($sformatf("wr_addr_%0d", i), ramaddr, 32'h40);
      checkVal($sformatf("wr_store_%0d", i), ramstore, 32'h12345678);
      checkVal($sformatf("wr_dwait_%0d", i), 32'(dwait), (i == 3) ? 32'h1 : 32'h3);
    end
    startCycle();
    dWEN     = '0;
    ramstate = FREE;
    sample();
    checkVal("wr_after_wen", 32'(ramWEN), 32'h0);
    checkVal("wr_after_store", ramstore, 32'h0);

    // priority and fairness, rr wrapped to 0; caches drop a request once served
    startCycle();
    iaddr    = {32'h1100, 32'h1000};
    daddr    = {32'h2100, 32'h2000};
    dREN     = 2'b11;
    iREN     = 2'b11;
    ramstate = ACCESS;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        startCycle();
        dREN = dREN & prevDwait;
        iREN = iREN & prevIwait;
      end
      sample();
      prevDwait = dwait;
      prevIwait = iwait;
      checkVal($sformatf("pri_addr_%0d", k), ramaddr, EXP_ADDR[k]);
      checkVal($sformatf("pri_ren_%0d", k), 32'(ramREN), EXP_REN[k]);
      checkVal($sformatf("pri_wait_%0d", k), {28'h0, dwait, iwait}, EXP_WAIT[k]);
    end

    // abort: core 0 read dropped during BUSY (rr is 0)
    startCycle();
    dREN         = 2'b01;
    iREN         = '0;
    daddr[31:0]  = 32'h300;
    ramstate     = BUSY;
    sample();
    checkVal("ab_idle_ren", 32'(ramREN), 32'h0);
    startCycle();
    sample();
    checkVal("ab_ren", 32'(ramREN), 32'h1);
    checkVal("ab_addr", ramaddr, 32'h300);
    startCycle();
    dREN = '0;
    sample();
    checkVal("ab_drop_ren", 32'(ramREN), 32'h0);
    checkVal("ab_drop_addr", ramaddr, 32'h0);
    checkVal("ab_drop_dwait", 32'(dwait), 32'h3);
    startCycle();
    iREN     = 2'b11;
    ramstate = ACCESS;
    sample();
    checkVal("ab_idle2_ren", 32'(ramREN), 32'h0);
    startCycle();
    sample();
    checkVal("ab_rr_addr", ramaddr, 32'h1000);
    checkVal("ab_rr_iwait", 32'(iwait), 32'h2);
    startCycle();
    iREN = '0;
    sample();

    // ERROR retried, then reset mid-transfer (rr is 1)
    startCycle();
    dREN          = 2'b10;
    daddr[63:32]  = 32'h500;
    ramstate      = ERROR;
    sample();
    for (int i = 0; i < 5; i++) begin
      startCycle();
      sample();
      checkVal($sformatf("err_ren_%0d", i), 32'(ramREN), 32'h1);
      checkVal($sformatf("err_addr_%0d", i), ramaddr, 32'h500);
      checkVal($sformatf("err_dwait_%0d", i), 32'(dwait), 32'h3);
    end
    startCycle();
    #1;
    nRST = 1'b0;
    #1;
    checkVal("err_rst_ren", 32'(ramREN), 32'h0);
    checkVal("err_rst_addr", ramaddr, 32'h0);
    checkVal("err_rst_dwait", 32'(dwait), 32'h3);
    dREN = '0;
    startCycle();
    nRST     = 1'b1;
    iREN     = 2'b11;
    ramstate = ACCESS;
    sample();
    checkVal("rel_idle_ren", 32'(ramREN), 32'h0);
    startCycle();
    sample();
    checkVal("rel_addr", ramaddr, 32'h1000);
    checkVal("rel_iwait", 32'(iwait), 32'h2);
    startCycle();
    iREN = '0;
    sample();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
